// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with a small transmit FIFO; frames leave back-to-back.
// Start bit appears one clock after the push; tx_rdy drops while the FIFO is full, and pushes made while full are dropped and set ovfl.
module uart_tx_fifo #(
    parameter int unsigned BAUD_DIV   = 34,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_rdy,
    output logic                 TX,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 ovfl
);

    localparam int unsigned NB = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
    localparam int unsigned BW = $clog2(BAUD_DIV);
    localparam int unsigned CW = $clog2(NB + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned OW = AW + 1;

    if (BAUD_DIV < 2 || BAUD_DIV > 65535) begin : g_chk_baud
        $error("uart_tx_fifo: BAUD_DIV must be 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY_EN > 1 || PARITY_ODD > 1) begin : g_chk_par
        $error("uart_tx_fifo: PARITY_EN and PARITY_ODD must be 0 or 1");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e                 state_q, state_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic [CW-1:0]          bit_q, bit_d;
    logic [NB-1:0]          shreg_q, shreg_d;
    logic [OW-1:0]          cnt_q, cnt_d;
    logic [AW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic                   rdy_q, rdy_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   ovfl_q, ovfl_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

    logic                   full, nempty, push, pop, shift_evt, frame_end;
    logic [NB-1:0]          frame;

    assign full      = (cnt_q == OW'(FIFO_DEPTH));
    assign nempty    = (cnt_q != '0);
    assign push      = trmt && !full;
    assign shift_evt = (state_q == SHIFT) && (baud_q == BW'(BAUD_DIV - 1));
    assign frame_end = shift_evt && (bit_q == CW'(NB - 1));
    // Reloading on the final shift event is what makes frames abut with no idle gap.
    assign pop       = nempty && ((state_q == IDLE) || frame_end);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (nempty) state_d = SHIFT;
            SHIFT:   if (frame_end && !nempty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame              = '1;
        frame[0]           = 1'b0;
        frame[DATA_BITS:1] = mem_q[rptr_q];
        if (PARITY_EN != 0) begin
            frame[DATA_BITS+1] = (^mem_q[rptr_q]) ^ 1'(PARITY_ODD);
        end

        baud_d  = (state_q == IDLE || shift_evt) ? '0 : baud_q + BW'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        if (pop) begin
            bit_d   = '0;
            shreg_d = frame;
        end else if (shift_evt) begin
            bit_d   = bit_q + CW'(1);
            shreg_d = {1'b1, shreg_q[NB-1:1]};
        end

        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + OW'(1);
            2'b01:   cnt_d = cnt_q - OW'(1);
            default: cnt_d = cnt_q;
        endcase
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;

        rdy_d  = (cnt_d != OW'(FIFO_DEPTH));
        busy_d = (state_d == SHIFT);
        done_d = frame_end;
        ovfl_d = ovfl_q || (trmt && full);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '1;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovfl_q  <= 1'b0;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovfl_q  <= ovfl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= tx_data;
    end

    assign TX      = shreg_q[0];
    assign tx_rdy  = rdy_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;
    assign ovfl    = ovfl_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the fixed 8N1 UART transmitter in the logic-analyzer capture/readout path.
- Adds a configurable baud divisor, data width, optional parity and 1 or 2 stop bits.
- Adds a small transmit FIFO, so the host can queue several bytes.
- Frames leave back-to-back, with no idle gap between them.

Parameters:
BAUD_DIV, 34, clocks per bit period; legal range 2..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
STOP_BITS, 1, number of stop bits; 1 or 2.
FIFO_DEPTH, 4, FIFO entries; power of 2, minimum 2.

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  reset, synchronous, active-low.
trmt  input  1  push request; tx_data is written to the FIFO when trmt=1 and tx_rdy=1.
tx_data  input  DATA_BITS  frame payload, sent LSB first.
tx_rdy  output  1  FIFO not full (registered).
TX  output  1  serial line, idle high (registered).
tx_busy  output  1  a frame is being shifted, or the FIFO is non-empty.
tx_done  output  1  one-cycle pulse at the end of the last stop bit of each frame.
ovfl  output  1  sticky: set when a push is attempted while full; cleared only by reset.

Behaviour:
- Reset: rst_n=0 at a posedge does all of the following at that edge, including mid-frame:
  - TX=1, tx_rdy=1, tx_busy=0, tx_done=0, ovfl=0.
  - FIFO emptied; baud and bit counters cleared; FSM to IDLE.
  - The partial frame is abandoned, not completed.
- Frame format:
  - Start bit 0, then DATA_BITS data bits LSB first.
  - Then the parity bit if PARITY_EN: XOR of the data bits, XORed with PARITY_ODD.
  - Then STOP_BITS bits of 1.
  - Frame length NB = 1 + DATA_BITS + PARITY_EN + STOP_BITS bits.
- Bit timing: every bit, including the start bit and each stop bit, holds TX for exactly BAUD_DIV clocks.
- Baud counter: counts 0..BAUD_DIV-1. The shift event fires when it equals BAUD_DIV-1; the counter then wraps to 0.
- FIFO:
  - Registered occupancy count; tx_rdy = (count != FIFO_DEPTH).
  - Push and pop on the same edge with count non-zero and not full: count unchanged.
  - Push while full is dropped, even if a pop occurs on the same edge; ovfl is set.
- FSM states: IDLE and SHIFT.
  - IDLE: if the FIFO is non-empty, pop the head, load the shift register with the complete frame, go to SHIFT. TX takes the start bit (0) at that same edge.
  - SHIFT: on each shift event, advance one bit and increment the bit counter.
  - When the bit counter reaches NB (end of the last stop bit), tx_done=1 for that one cycle.
  - At that point, if the FIFO is non-empty: pop and load the next frame on the same edge, so TX goes from stop to start with no gap; stay in SHIFT.
  - Otherwise go to IDLE with TX=1.
- Latency from empty and idle:
  - trmt is sampled at edge k (push); pop/load at edge k+1; TX=0 from edge k+1.
  - The first data bit appears at edge k+1+BAUD_DIV.
- tx_busy:
  - Is 1 from the edge after the push until tx_done of the last queued frame.
  - Drops to 0 on the same edge that TX returns to idle.
- Widths:
  - Baud counter is clog2(BAUD_DIV) bits.
  - Bit counter is clog2(NB+1) bits.
  - Shift register is NB bits, shifted right with 1 fill.
- Parameter checks: out-of-range parameters are rejected at elaboration with $error.

Test Plan:
1. Defaults; push 0xA5 at edge 0 → TX bit sequence 0,1,0,1,0,0,1,0,1,1, each held 34 clocks starting at edge 1; tx_done pulse at edge 341; TX=1 and tx_busy=0 afterwards.
2. PARITY_EN=1: PARITY_ODD=0, send 0x07 → parity bit 1. PARITY_ODD=1, send 0x07 → parity bit 0. Frame is 11 bits = 374 clocks.
3. STOP_BITS=2, DATA_BITS=7: push 0x55 and 0x2A on consecutive edges → two 10-bit frames; second start bit begins exactly 340 clocks after the first; two tx_done pulses 340 clocks apart.
4. Overflow: FIFO_DEPTH=4; trmt=1 for 6 consecutive edges with data 1..6 → first five accepted; at the sixth edge tx_rdy=0, the push is dropped and ovfl=1. Bytes 1..5 are transmitted in order, with no gaps.
5. Mid-frame reset: rst_n=0 for one edge during data bit 3 of 0xFF with two bytes queued → TX=1, tx_busy=0, tx_rdy=1 at that edge; no further frames or tx_done.
6. BAUD_DIV=2 corner: send 0x00 → each bit lasts exactly 2 clocks; frame is 20 clocks; tx_done pulses once.
